// File: rtl/johnson_seq_gen_if.sv
// rtl/johnson_seq_gen_if.sv - control and pattern bundle of the Johnson sequence generator
interface johnson_seq_gen_if #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 8
);
    localparam int PH_W = $clog2(2 * WIDTH);

    logic               ena;
    logic [PRESC_W-1:0] step_div;
    logic               dir;
    logic               hold;
    logic               load;
    logic [WIDTH-1:0]   load_val;
    logic [WIDTH-1:0]   q;
    logic [PH_W-1:0]    phase;
    logic               adv;
    logic               wrap;
    logic               illegal;

    modport master (
        output ena, step_div, dir, hold, load, load_val,
        input  q, phase, adv, wrap, illegal
    );

    modport slave (
        input  ena, step_div, dir, hold, load, load_val,
        output q, phase, adv, wrap, illegal
    );
endinterface

// File: rtl/johnson_seq_gen.sv
// rtl/johnson_seq_gen.sv - programmable twisted-ring pattern source with prescaler and self-correction
module johnson_seq_gen #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    johnson_seq_gen_if.slave bus
);
    localparam int                PH_W = $clog2(2 * WIDTH);
    localparam logic [PH_W-1:0]   LAST = PH_W'(2 * WIDTH - 1);

    logic [PRESC_W-1:0] cnt_r;
    logic [WIDTH-1:0]   q_r;
    logic [PH_W-1:0]    ph_r;
    logic               adv_r;
    logic               wrap_r;
    logic               ill_r;
    logic               tick;

    // Legal patterns are a run of ones anchored at the LSB, or its complement.
    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] n;
        n = ~v;
        return ((v & (v + WIDTH'(1))) == '0) || ((n & (n + WIDTH'(1))) == '0);
    endfunction

    function automatic logic [PH_W-1:0] phase_of(input logic [WIDTH-1:0] v);
        int pc;
        pc = 0;
        for (int i = 0; i < WIDTH; i++) begin
            pc += {31'b0, v[i]};
        end
        return v[WIDTH-1] ? PH_W'(2 * WIDTH - pc) : PH_W'(pc);
    endfunction

    // ">=" rather than "==" so a lowered divider cannot strand the counter above it.
    assign tick = (cnt_r >= bus.step_div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            q_r    <= '0;
            ph_r   <= '0;
            adv_r  <= 1'b0;
            wrap_r <= 1'b0;
            ill_r  <= 1'b0;
        end else if (!bus.ena) begin
            adv_r  <= 1'b0;
            wrap_r <= 1'b0;
            ill_r  <= 1'b0;
        end else begin
            adv_r  <= 1'b0;
            wrap_r <= 1'b0;
            ill_r  <= 1'b0;
            if (bus.load) begin
                cnt_r <= '0;
                if (is_legal(bus.load_val)) begin
                    q_r  <= bus.load_val;
                    ph_r <= phase_of(bus.load_val);
                end else begin
                    q_r   <= '0;
                    ph_r  <= '0;
                    ill_r <= 1'b1;
                end
            end else begin
                cnt_r <= tick ? '0 : cnt_r + PRESC_W'(1);
                if (tick && !bus.hold) begin
                    adv_r <= 1'b1;
                    if (!is_legal(q_r)) begin
                        // Upset ring: restart from the all-zero pattern instead of shifting garbage.
                        q_r   <= '0;
                        ph_r  <= '0;
                        ill_r <= 1'b1;
                    end else if (bus.dir) begin
                        q_r    <= {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
                        ph_r   <= (ph_r == LAST) ? '0 : ph_r + PH_W'(1);
                        wrap_r <= (ph_r == LAST);
                    end else begin
                        q_r    <= {~q_r[0], q_r[WIDTH-1:1]};
                        ph_r   <= (ph_r == '0) ? LAST : ph_r - PH_W'(1);
                        wrap_r <= (ph_r == '0);
                    end
                end
            end
        end
    end

    assign bus.q       = q_r;
    assign bus.phase   = ph_r;
    assign bus.adv     = adv_r;
    assign bus.wrap    = wrap_r;
    assign bus.illegal = ill_r;
endmodule

// File: tb/tb_johnson_seq_gen.sv
// tb/tb_johnson_seq_gen.sv - directed bench for johnson_seq_gen
module tb_johnson_seq_gen;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    johnson_seq_gen_if #(.WIDTH(8), .PRESC_W(8)) bus ();

    johnson_seq_gen #(.WIDTH(8), .PRESC_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] fwd_q [16];
    logic [7:0] rev_q [16];
    logic [3:0] adv_a [8];
    logic [3:0] adv_b [4];

    initial begin
        total = 0;
        bad   = 0;
        fwd_q = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                  8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        rev_q = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                  8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
        adv_a = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1};
        adv_b = '{4'd1, 4'd0, 4'd0, 4'd1};

        rst_n        = 1'b0;
        bus.ena      = 1'b0;
        bus.step_div = 8'd0;
        bus.dir      = 1'b1;
        bus.hold     = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 8'h00;
        step();
        step();
        chk("rst_q", 32'(bus.q), 32'h00);
        chk("rst_phase", 32'(bus.phase), 32'd0);
        chk("rst_pulses", {29'b0, bus.adv, bus.wrap, bus.illegal}, 32'd0);

        rst_n   = 1'b1;
        bus.ena = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("fwd_q%0d", i), 32'(bus.q), 32'(fwd_q[i]));
            chk($sformatf("fwd_ph%0d", i), 32'(bus.phase), 32'((i + 1) % 16));
            chk($sformatf("fwd_adv%0d", i), 32'(bus.adv), 32'd1);
            chk($sformatf("fwd_wrap%0d", i), 32'(bus.wrap), (i == 15) ? 32'd1 : 32'd0);
        end

        bus.dir = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("rev_q%0d", i), 32'(bus.q), 32'(rev_q[i]));
            chk($sformatf("rev_ph%0d", i), 32'(bus.phase), 32'(15 - i));
            chk($sformatf("rev_wrap%0d", i), 32'(bus.wrap), (i == 0) ? 32'd1 : 32'd0);
        end

        bus.step_div = 8'd3;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("div3_adv%0d", i), 32'(bus.adv), 32'(adv_a[i]));
        end
        bus.step_div = 8'd200;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("div200_adv%0d", i), 32'(bus.adv), 32'd0);
        end
        bus.step_div = 8'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("div2_adv%0d", i), 32'(bus.adv), 32'(adv_b[i]));
        end

        bus.step_div = 8'd255;
        bus.load     = 1'b1;
        bus.load_val = 8'h1F;
        step();
        chk("load1f_q", 32'(bus.q), 32'h1F);
        chk("load1f_ph", 32'(bus.phase), 32'd5);
        chk("load1f_pulses", {29'b0, bus.adv, bus.wrap, bus.illegal}, 32'd0);
        bus.load_val = 8'h5A;
        step();
        bus.load = 1'b0;
        chk("load5a_q", 32'(bus.q), 32'h00);
        chk("load5a_ph", 32'(bus.phase), 32'd0);
        chk("load5a_ill", 32'(bus.illegal), 32'd1);
        step();
        chk("load5a_ill_clr", 32'(bus.illegal), 32'd0);

        bus.step_div = 8'd0;
        bus.hold     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("hold_q%0d", i), 32'(bus.q), 32'h00);
            chk($sformatf("hold_adv%0d", i), 32'(bus.adv), 32'd0);
        end
        bus.hold     = 1'b0;
        bus.step_div = 8'd2;
        step();
        chk("pre_frz_adv", 32'(bus.adv), 32'd0);
        bus.ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("frz_q%0d", i), 32'(bus.q), 32'h00);
            chk($sformatf("frz_adv%0d", i), 32'(bus.adv), 32'd0);
        end
        bus.ena = 1'b1;
        step();
        chk("thaw_adv0", 32'(bus.adv), 32'd0);
        step();
        chk("thaw_adv1", 32'(bus.adv), 32'd1);
        chk("thaw_q", 32'(bus.q), 32'h80);
        chk("thaw_ph", 32'(bus.phase), 32'd15);
        chk("thaw_wrap", 32'(bus.wrap), 32'd1);

        bus.ena = 1'b0;
        force dut.q_r = 8'h24;
        bus.step_div = 8'd0;
        bus.ena      = 1'b1;
        step();
        chk("seu_ill", 32'(bus.illegal), 32'd1);
        chk("seu_adv", 32'(bus.adv), 32'd1);
        chk("seu_ph", 32'(bus.phase), 32'd0);
        chk("seu_wrap", 32'(bus.wrap), 32'd0);
        release dut.q_r;

        bus.load     = 1'b1;
        bus.load_val = 8'h1F;
        step();
        bus.load = 1'b0;
        bus.dir  = 1'b1;
        step();
        chk("pre_rst_q", 32'(bus.q), 32'h3F);
        chk("pre_rst_ph", 32'(bus.phase), 32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_q", 32'(bus.q), 32'h00);
        chk("async_rst_ph", 32'(bus.phase), 32'd0);
        step();
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
